// File: rtl/aes_pkg.sv
// Shared AES definitions for the SubBytes datapath.
//   byte_t        : one state byte
//   sub_state_t   : control states of the time-multiplexed SubBytes engine
//   AES_SBOX_FWD  : FIPS-197 forward S-box, indexed by input byte
//   AES_SBOX_INV  : FIPS-197 inverse S-box, indexed by input byte
//   aes_sub()     : single-byte substitution, forward or inverse
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } sub_state_t;

    localparam byte_t AES_SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t AES_SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic byte_t aes_sub(input byte_t b, input bit inv);
        return inv ? AES_SBOX_INV[b] : AES_SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box lane: purely combinational table lookup.
//   i_byte : byte to substitute
//   o_byte : FIPS-197 inverse S-box of i_byte
module aes_inv_sbox
    import aes_pkg::*;
(
    input  byte_t i_byte,
    output byte_t o_byte
);

    assign o_byte = AES_SBOX_INV[i_byte];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box lane: purely combinational table lookup.
//   i_byte : byte to substitute
//   o_byte : FIPS-197 forward S-box of i_byte
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t i_byte,
    output byte_t o_byte
);

    assign o_byte = AES_SBOX_FWD[i_byte];

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Time-multiplexed AES SubBytes (forward or inverse) over a full state word.
// LANES S-box lanes substitute LANES bytes per beat, in place in a work
// register, over WORD_BYTES/LANES beats. The result is then held until the
// downstream stage takes it.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_valid      : input word valid
//   o_ready      : engine accepts a word this cycle (combinational from i_ready in HOLD)
//   i_data       : input word, byte k = bits [8k+7:8k]
//   i_inverse    : 1 = inverse SubBytes, sampled with i_data (ignored when INVERSE_EN=0)
//   o_valid      : result word valid
//   i_ready      : downstream accepts the result
//   o_data       : substituted word, same byte order
//   o_busy       : engine is not idle
module aes_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int WORD_BYTES = 16,
    parameter int LANES      = 4,
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [8*WORD_BYTES-1:0] i_data,
    input  logic                    i_inverse,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [8*WORD_BYTES-1:0] o_data,
    output logic                    o_busy
);

    localparam int BEATS = (LANES >= 1) ? (WORD_BYTES / LANES) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int W     = 8 * WORD_BYTES;

    generate
        if (LANES < 1 || (WORD_BYTES % LANES) != 0) begin : g_bad_lanes
            $error("aes_sub_bytes_engine: LANES must be >= 1 and divide WORD_BYTES");
        end
    endgenerate

    sub_state_t       state_reg, state_next;
    logic [CNT_W-1:0] beat_reg, beat_next;
    logic [W-1:0]     work_reg, work_next;
    logic             accept;
    logic             last_beat;

    byte_t lane_in  [LANES];
    byte_t lane_out [LANES];
    byte_t fwd_out  [LANES];

    genvar gi;

    // Handshake and status. o_ready reopens in HOLD as soon as the result is
    // taken so a new word can enter in the same cycle.
    assign o_ready   = (state_reg == IDLE) || ((state_reg == HOLD) && i_ready);
    assign accept    = i_valid && o_ready;
    assign o_valid   = (state_reg == HOLD);
    assign o_busy    = (state_reg != IDLE);
    assign o_data    = work_reg;
    assign last_beat = (beat_reg == CNT_W'(BEATS - 1));

    // Lane b*LANES+gi feeds lane gi during beat b.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_fwd_lane
            assign lane_in[gi] = work_reg[8*(int'(beat_reg)*LANES + gi) +: 8];
            aes_sbox u_fwd_sbox (
                .i_byte (lane_in[gi]),
                .o_byte (fwd_out[gi])
            );
        end
    endgenerate

    // Inverse lanes and the mode flag exist only when inverse support is built.
    generate
        if (INVERSE_EN) begin : g_inv
            logic  mode_reg;
            byte_t inv_out [LANES];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    mode_reg <= 1'b0;
                end else if (accept) begin
                    mode_reg <= i_inverse;
                end
            end

            for (gi = 0; gi < LANES; gi++) begin : g_inv_lane
                aes_inv_sbox u_inv_sbox (
                    .i_byte (lane_in[gi]),
                    .o_byte (inv_out[gi])
                );
                assign lane_out[gi] = mode_reg ? inv_out[gi] : fwd_out[gi];
            end
        end else begin : g_fwd_only
            logic unused_inverse;
            assign unused_inverse = i_inverse;
            for (gi = 0; gi < LANES; gi++) begin : g_pass
                assign lane_out[gi] = fwd_out[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        work_next  = work_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SUB;
                    beat_next  = '0;
                    work_next  = i_data;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    work_next[8*(int'(beat_reg)*LANES + l) +: 8] = lane_out[l];
                end
                if (last_beat) begin
                    state_next = HOLD;
                    beat_next  = '0;
                end else begin
                    beat_next = beat_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                if (i_ready) begin
                    if (accept) begin
                        state_next = SUB;
                        beat_next  = '0;
                        work_next  = i_data;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            work_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            work_reg  <= work_next;
        end
    end

endmodule
